// File: rtl/vga_pmod_capture.sv
// vga_pmod_capture: recovers pixel coordinates and colour from a
// TinyVGA PMOD stream by locking free-running counters to sync edges.
module vga_pmod_capture #(
  parameter int H_DISPLAY    = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_TOTAL      = 800,
  parameter int V_DISPLAY    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_TOTAL      = 525
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pmod,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [1:0] pix_r,
  output logic [1:0] pix_g,
  output logic [1:0] pix_b,
  output logic       frame_start,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic [7:0] frame_count
);

  localparam logic [9:0] HD  = 10'(H_DISPLAY);
  localparam logic [9:0] HSS = 10'(H_SYNC_START);
  localparam logic [9:0] HT  = 10'(H_TOTAL);
  localparam logic [9:0] VD  = 10'(V_DISPLAY);
  localparam logic [9:0] VSS = 10'(V_SYNC_START);
  localparam logic [9:0] VT  = 10'(V_TOTAL);

  typedef enum logic [1:0] {SEARCH, HLOCK, LOCKED} state_t;

  state_t     state_q, state_d, state_h;
  logic [7:0] s1_q, s1_d;
  logic       hs_prev_q, hs_prev_d;
  logic       vs_prev_q, vs_prev_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic [9:0] h_inc, v_inc;
  logic       hs_edge, vs_edge, h_wrap, h_mis, v_mis;
  logic       valid_q, valid_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic       fs_q, fs_d;
  logic       herr_q, herr_d, verr_q, verr_d;
  logic [7:0] fcnt_q, fcnt_d;

  always_comb begin
    s1_d      = pmod;
    hs_prev_d = s1_q[7];
    vs_prev_d = s1_q[3];
    hs_edge   = hs_prev_q & ~s1_q[7];
    vs_edge   = vs_prev_q & ~s1_q[3];

    // h_d/v_d are the coordinates of the pixel currently held in S1
    h_wrap = (h_q >= HT - 10'd1);
    h_inc  = h_wrap ? 10'd0 : h_q + 10'd1;
    v_inc  = v_q;
    if (h_wrap && !hs_edge)
      v_inc = (v_q >= VT - 10'd1) ? 10'd0 : v_q + 10'd1;
    h_d = hs_edge ? HSS : h_inc;
    v_d = vs_edge ? VSS : v_inc;

    h_mis = hs_edge && (h_inc != HSS);
    v_mis = (h_d != 10'd0) || (v_inc != VSS);

    // h rule is resolved before the v rule within one cycle
    state_h = state_q;
    herr_d  = 1'b0;
    if (hs_edge) begin
      if (state_q == SEARCH) begin
        state_h = HLOCK;
      end else if (h_mis) begin
        state_h = HLOCK;
        herr_d  = 1'b1;
      end
    end

    state_d = state_h;
    verr_d  = 1'b0;
    if (vs_edge) begin
      if (state_h == HLOCK)
        state_d = LOCKED;
      else if (state_h == LOCKED && v_mis)
        verr_d = 1'b1;
    end

    valid_d = (state_d == LOCKED) && (h_d < HD) && (v_d < VD);
    fs_d    = valid_d && (h_d == 10'd0) && (v_d == 10'd0);
    x_d     = valid_d ? h_d : x_q;
    y_d     = valid_d ? v_d : y_q;
    r_d     = valid_d ? {s1_q[0], s1_q[4]} : r_q;
    g_d     = valid_d ? {s1_q[1], s1_q[5]} : g_q;
    b_d     = valid_d ? {s1_q[2], s1_q[6]} : b_q;
    fcnt_d  = fs_d ? fcnt_q + 8'd1 : fcnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SEARCH;
      s1_q      <= 8'b1000_1000;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      h_q       <= 10'd0;
      v_q       <= 10'd0;
      valid_q   <= 1'b0;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      r_q       <= 2'd0;
      g_q       <= 2'd0;
      b_q       <= 2'd0;
      fs_q      <= 1'b0;
      herr_q    <= 1'b0;
      verr_q    <= 1'b0;
      fcnt_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
      h_q       <= h_d;
      v_q       <= v_d;
      valid_q   <= valid_d;
      x_q       <= x_d;
      y_q       <= y_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      fs_q      <= fs_d;
      herr_q    <= herr_d;
      verr_q    <= verr_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign pix_valid   = valid_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign pix_r       = r_q;
  assign pix_g       = g_q;
  assign pix_b       = b_q;
  assign frame_start = fs_q;
  assign locked      = (state_q == LOCKED);
  assign h_err       = herr_q;
  assign v_err       = verr_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_vga_pmod_capture.sv
// tb_vga_pmod_capture: scoreboard bench on a reduced video timing
// (12x7 total, 8x4 visible) so many frames fit in a short run.
module tb_vga_pmod_capture;

  localparam int HD  = 8;
  localparam int HSS = 10;
  localparam int HT  = 12;
  localparam int VD  = 4;
  localparam int VSS = 5;
  localparam int VT  = 7;
  localparam int FR  = HT * VT;

  localparam int M_SEARCH = 0;
  localparam int M_HLOCK  = 1;
  localparam int M_LOCKED = 2;

  typedef struct packed {
    logic       valid;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       fs;
    logic       lk;
    logic       he;
    logic       ve;
    logic [7:0] fc;
  } outw_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pmod;
  logic       pix_valid;
  logic [9:0] pix_x, pix_y;
  logic [1:0] pix_r, pix_g, pix_b;
  logic       frame_start, locked, h_err, v_err;
  logic [7:0] frame_count;

  always #5 clk = ~clk;

  vga_pmod_capture #(
    .H_DISPLAY   (HD),
    .H_SYNC_START(HSS),
    .H_TOTAL     (HT),
    .V_DISPLAY   (VD),
    .V_SYNC_START(VSS),
    .V_TOTAL     (VT)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .pmod       (pmod),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_r      (pix_r),
    .pix_g      (pix_g),
    .pix_b      (pix_b),
    .frame_start(frame_start),
    .locked     (locked),
    .h_err      (h_err),
    .v_err      (v_err),
    .frame_count(frame_count)
  );

  outw_t exp_q[$];
  int    checks = 0;
  int    failures = 0;

  logic       rst_req = 1'b1;
  logic       rst_applied = 1'b0;
  int         gx = 0;
  int         gy = 0;
  logic       f_early_h = 1'b0;
  logic       f_late_v = 1'b0;
  logic       supp = 1'b0;
  int         ms = M_SEARCH;
  logic       hprev = 1'b1;
  logic       vprev = 1'b1;
  logic [7:0] fcnt = 8'd0;
  logic [9:0] last_x = '0;
  logic [9:0] last_y = '0;
  logic [5:0] last_c = '0;
  int         n_herr = 0;
  int         n_verr = 0;
  int         n_p53 = 0;
  logic       saw_wrap = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic outw_t obs_now();
    outw_t o;
    o.valid = pix_valid;
    o.x     = pix_x;
    o.y     = pix_y;
    o.r     = pix_r;
    o.g     = pix_g;
    o.b     = pix_b;
    o.fs    = frame_start;
    o.lk    = locked;
    o.he    = h_err;
    o.ve    = v_err;
    o.fc    = frame_count;
    return o;
  endfunction

  task automatic drive();
    logic       hs, vs, early, late, hedge, vedge;
    logic [7:0] p;
    outw_t      e;
    rst_applied = reset;
    reset = rst_req;
    early = 1'b0;
    late  = 1'b0;
    if (f_early_h && gx == HSS - 1) begin
      gx = HSS;
      f_early_h = 1'b0;
      early = 1'b1;
    end
    if (gx == 0 && supp) begin
      gy = VSS;
      supp = 1'b0;
      late = 1'b1;
    end else if (f_late_v && gx == 0 && gy == VSS) begin
      supp = 1'b1;
      f_late_v = 1'b0;
    end
    hs = (gx < HSS);
    vs = !(gy >= VSS && !supp);
    p = (gx == 5 && gy == 3) ? 8'b0111_0111 : 8'($urandom);
    p[7] = hs;
    p[3] = vs;
    pmod = p;
    if (reset) begin
      ms = M_SEARCH;
      hprev = 1'b1;
      vprev = 1'b1;
      fcnt = 8'd0;
      last_x = '0;
      last_y = '0;
      last_c = '0;
      exp_q.delete();
    end else begin
      hedge = hprev && !hs;
      vedge = vprev && !vs;
      hprev = hs;
      vprev = vs;
      e = '0;
      if (hedge) begin
        if (ms == M_SEARCH) ms = M_HLOCK;
        else if (early) begin
          e.he = 1'b1;
          ms = M_HLOCK;
        end
      end
      if (vedge) begin
        if (ms == M_HLOCK) ms = M_LOCKED;
        else if (ms == M_LOCKED && late) e.ve = 1'b1;
      end
      e.valid = (ms == M_LOCKED) && gx < HD && gy < VD;
      if (e.valid) begin
        last_x = 10'(gx);
        last_y = 10'(gy);
        last_c = {p[0], p[4], p[1], p[5], p[2], p[6]};
      end
      e.fs = e.valid && gx == 0 && gy == 0;
      if (e.fs) fcnt = fcnt + 8'd1;
      e.x  = last_x;
      e.y  = last_y;
      {e.r, e.g, e.b} = last_c;
      e.lk = (ms == M_LOCKED);
      e.fc = fcnt;
      exp_q.push_back(e);
    end
    gx++;
    if (gx == HT) begin
      gx = 0;
      gy++;
      if (gy == VT) gy = 0;
    end
  endtask

  task automatic step();
    outw_t e, o;
    @(negedge clk);
    o = obs_now();
    if (rst_applied) begin
      check("reset_outs", 64'(o), 64'd0);
    end else if (exp_q.size() > 2) begin
      e = exp_q.pop_front();
      check("outs", 64'(o), 64'(e));
      if (e.valid && e.x == 10'd5 && e.y == 10'd3) begin
        n_p53++;
        check("pix_5_3", 64'({o.valid, o.x, o.y, o.r, o.g, o.b}),
              64'({1'b1, 10'd5, 10'd3, 6'h3f}));
      end
      if (e.fs && e.fc == 8'd0) begin
        check("fcnt_wrap", 64'(o.fc), 64'd0);
      end
      if (o.fs && o.fc == 8'd0) saw_wrap = 1'b1;
      if (o.he) n_herr++;
      if (o.ve) n_verr++;
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    pmod  = 8'h88;
    repeat (4) step();
    rst_req = 1'b0;
    repeat (4 * FR) step();
    f_early_h = 1'b1;
    repeat (2 * FR) step();
    f_late_v = 1'b1;
    repeat (2 * FR) step();
    n = 0;
    while (!(gx == 4 && gy == 2) && n < 2 * FR) begin
      step();
      n++;
    end
    rst_req = 1'b1;
    repeat (3) step();
    rst_req = 1'b0;
    repeat (258 * FR) step();
    repeat (3) step();
    check("h_err_pulses", 64'(n_herr), 64'd1);
    check("v_err_pulses", 64'(n_verr), 64'd1);
    check("wrap_seen", 64'(saw_wrap), 64'd1);
    check("pix_5_3_seen", 64'(n_p53 > 0), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
